// File: rtl/token_ring_pkg.sv
// Shared types and helpers for the token ring arbiter.
// Holds the FSM state type, the default sizing constants and a one-hot
// rotate helper that works for any ring width up to MAX_N.
package token_ring_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 4;

  // Widest ring the rotate helper supports.
  localparam int MAX_N = 64;

  typedef enum logic {
    SCAN  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate the low n bits of v left by one; bit n-1 wraps into bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v,
                                             input int n);
    logic [MAX_N-1:0] r;
    r    = '0;
    r[0] = v[n-1];
    for (int i = 1; i < MAX_N; i++) begin
      if (i < n) r[i] = v[i-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/token_ring_arbiter_rr_next_finder.sv
// Combinational search for the next requester after the token position,
// walking left around the ring. Returns one-hot, or zero when req is empty.
// Used by the top only when TOKEN_SKIP_EN is defined.
module rr_next_finder
  import token_ring_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] token,
  input  logic [N-1:0] req,
  output logic [N-1:0] nxt
);

  int   tpos;
  int   idx;
  logic found;

  // Locate the token, then take the first request found rotating left from it.
  always_comb begin
    nxt   = '0;
    tpos  = 0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (token[i]) tpos = i;
    end
    for (int k = 1; k <= N; k++) begin
      idx = tpos + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        nxt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/token_ring_arbiter.sv
// Round-robin token ring arbiter for a shared datapath.
// A one-hot token circulates; the holder gets an exclusive grant for at most
// MAX_HOLD enabled cycles, after which the token always moves on.
// Optional build macro: TOKEN_SKIP_EN -- in SCAN the token jumps straight to
// the next requester instead of stepping one position per cycle.
module token_ring_arbiter
  import token_ring_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] token,
  output logic         busy,
  output logic         timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [N-1:0]     token_nxt, gnt_nxt, token_rot, token_adv;
  logic             busy_nxt, timeout_nxt, own_req;
  logic [MAX_N-1:0] rot_wide;

  assign rot_wide  = rotl1(MAX_N'(token), N);
  assign token_rot = rot_wide[N-1:0];
  assign own_req   = |(req & token);

`ifdef TOKEN_SKIP_EN
  logic [N-1:0] skip_tok;

  rr_next_finder #(.N(N)) u_next (
    .token (token),
    .req   (req),
    .nxt   (skip_tok)
  );

  // With nobody requesting the token stays put rather than spinning.
  assign token_adv = (|req) ? skip_tok : token;
`else
  assign token_adv = token_rot;
`endif

  // State, token, grant and hold counter registers; reset drops gnt at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      token    <= N'(1);
      gnt      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      token    <= token_nxt;
      gnt      <= gnt_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic: scan for the token holder, then hold its tenure.
  always_comb begin
    state_nxt   = state;
    token_nxt   = token;
    gnt_nxt     = gnt;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    unique case (state)
      SCAN: begin
        if (en) begin
          if (own_req) begin
            gnt_nxt   = token;
            busy_nxt  = 1'b1;
            hold_nxt  = CNT_W'(1);
            state_nxt = GRANT;
          end else begin
            token_nxt = token_adv;
          end
        end
      end
      GRANT: begin
        // A dropped request wins over a coincident expiry: no timeout pulse.
        if (!own_req || (en && hold_cnt == CNT_W'(MAX_HOLD))) begin
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          token_nxt   = token_rot;
          timeout_nxt = own_req;
          hold_nxt    = '0;
          state_nxt   = SCAN;
        end else if (en) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

endmodule

// File: tb/tb_token_ring_arbiter.sv
// Self-checking bench for token_ring_arbiter (N=4, MAX_HOLD=4).
// A behavioural model tracks token position as an index and the tenure
// length as a plain count; every step compares all outputs against it.
module tb_token_ring_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] token;
  logic         busy;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_tok;
  bit m_busy;
  int m_hold;
  bit m_to;

  token_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .token   (token),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [N-1:0] exp_tok();
    return N'(1 << m_tok);
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    return m_busy ? exp_tok() : '0;
  endfunction

  task automatic model_reset();
    m_tok  = 0;
    m_busy = 0;
    m_hold = 0;
    m_to   = 0;
  endtask

  // Apply the arbiter rules for one clock edge with inputs e/r.
  task automatic model_update(input logic e, input logic [N-1:0] r);
    m_to = 0;
    if (!m_busy) begin
      if (e) begin
        if (r[m_tok]) begin
          m_busy = 1;
          m_hold = 1;
        end else begin
`ifdef TOKEN_SKIP_EN
          for (int k = 1; k <= N; k++) begin
            if (r[(m_tok + k) % N]) begin
              m_tok = (m_tok + k) % N;
              break;
            end
          end
`else
          m_tok = (m_tok + 1) % N;
`endif
        end
      end
    end else begin
      if (!r[m_tok]) begin
        m_busy = 0;
        m_tok  = (m_tok + 1) % N;
      end else if (e && m_hold == MAX_HOLD) begin
        m_busy = 0;
        m_to   = 1;
        m_tok  = (m_tok + 1) % N;
      end else if (e) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  // Drive inputs, take one edge, advance the model, settle 1 time unit.
  task automatic step(input logic e, input logic [N-1:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    model_update(e, r);
    #1;
  endtask

  // Hold reset across an edge, leave inputs at e/r, release on a falling edge.
  task automatic do_reset(input logic e, input logic [N-1:0] r);
    rst = 1'b1;
    en  = e;
    req = r;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111);
      total++;
      if ({gnt, token, busy, timeout} !== {exp_gnt(), exp_tok(), m_busy, m_to}) begin
        bad++;
        $display("FAIL reset_prerun step %0d: got gnt=%b token=%b busy=%b to=%b want gnt=%b token=%b busy=%b to=%b",
                 i, gnt, token, busy, timeout, exp_gnt(), exp_tok(), m_busy, m_to);
      end
    end
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL reset_pregrant: gnt=%b want 0001", gnt);
    end
    // asynchronous reset mid-grant, checked before any further edge
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({token, gnt, busy, timeout} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got token=%b gnt=%b busy=%b to=%b want 0001 0000 0 0",
               token, gnt, busy, timeout);
    end
    model_reset();
  endtask

  task automatic test_timeout();
`ifdef TOKEN_SKIP_EN
    localparam int STEPS = 7;
    logic [N-1:0] tg [STEPS] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
    logic [N-1:0] tt [STEPS] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1};
    logic         to [STEPS] = '{0, 0, 0, 0, 1, 0, 0};
`else
    localparam int STEPS = 9;
    logic [N-1:0] tg [STEPS] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    logic [N-1:0] tt [STEPS] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h1};
    logic         to [STEPS] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
`endif
    do_reset(1'b1, 4'b0001);
    for (int i = 0; i < STEPS; i++) begin
      step(1'b1, 4'b0001);
      total++;
      if ({gnt, token, timeout} !== {tg[i], tt[i], to[i]}) begin
        bad++;
        $display("FAIL timeout_seq edge %0d: got gnt=%b token=%b to=%b want gnt=%b token=%b to=%b",
                 i + 1, gnt, token, timeout, tg[i], tt[i], to[i]);
      end
      total++;
      if ({gnt, token, busy, timeout} !== {exp_gnt(), exp_tok(), m_busy, m_to}) begin
        bad++;
        $display("FAIL timeout_model edge %0d: got %b %b %b %b want %b %b %b %b",
                 i + 1, gnt, token, busy, timeout, exp_gnt(), exp_tok(), m_busy, m_to);
      end
    end
  endtask

  task automatic test_walk();
`ifdef TOKEN_SKIP_EN
    localparam int GE = 2;
`else
    localparam int GE = 3;
`endif
    do_reset(1'b1, 4'b0100);
    for (int i = 1; i <= GE; i++) begin
      step(1'b1, 4'b0100);
      total++;
      if (gnt !== ((i == GE) ? 4'b0100 : 4'b0000)) begin
        bad++;
        $display("FAIL walk_gnt edge %0d: gnt=%b token=%b want gnt=%b",
                 i, gnt, token, (i == GE) ? 4'b0100 : 4'b0000);
      end
      total++;
      if (token !== exp_tok()) begin
        bad++;
        $display("FAIL walk_token edge %0d: token=%b want %b", i, token, exp_tok());
      end
    end
  endtask

  task automatic test_drop();
    do_reset(1'b1, 4'b0010);
    step(1'b1, 4'b0010);
    step(1'b1, 4'b0010);
    step(1'b1, 4'b0010);
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL drop_granted: gnt=%b want 0010", gnt);
    end
    step(1'b1, 4'b0000);
    total++;
    if ({gnt, token, busy, timeout} !== {4'b0000, 4'b0100, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL drop_release: got gnt=%b token=%b busy=%b to=%b want 0000 0100 0 0",
               gnt, token, busy, timeout);
    end
  endtask

  task automatic test_all_req();
    logic [N-1:0] order [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [N-1:0] prev;
    int ntimeout;
    int ngrant;
    int multi;
    ntimeout = 0;
    ngrant   = 0;
    multi    = 0;
    prev     = '0;
    do_reset(1'b1, 4'b1111);
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 4'b1111);
      if (timeout) ntimeout++;
      if ($countones(gnt) > 1) multi++;
      if (gnt != 0 && prev == 0) begin
        total++;
        if (ngrant >= 5 || gnt !== order[ngrant]) begin
          bad++;
          $display("FAIL allreq_order grant %0d: gnt=%b", ngrant, gnt);
        end
        ngrant++;
      end
      prev = gnt;
      total++;
      if ({gnt, token, busy, timeout} !== {exp_gnt(), exp_tok(), m_busy, m_to}) begin
        bad++;
        $display("FAIL allreq_model edge %0d: got %b %b %b %b want %b %b %b %b",
                 i + 1, gnt, token, busy, timeout, exp_gnt(), exp_tok(), m_busy, m_to);
      end
    end
    total++;
    if (ntimeout !== 5 || ngrant !== 5 || multi !== 0) begin
      bad++;
      $display("FAIL allreq_counts: timeouts=%0d grants=%0d multihot=%0d want 5 5 0",
               ntimeout, ngrant, multi);
    end
  endtask

  task automatic test_enable();
    int guard;
    do_reset(1'b0, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b1000);
      total++;
      if ({token, gnt} !== {4'b0001, 4'b0000}) begin
        bad++;
        $display("FAIL en_frozen_scan edge %0d: token=%b gnt=%b want 0001 0000", i, token, gnt);
      end
    end
    guard = 0;
    while (gnt !== 4'b1000 && guard < 20) begin
      step(1'b1, 4'b1000);
      guard++;
    end
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL en_grant_reach: gnt=%b want 1000 within 20 edges", gnt);
    end
    step(1'b1, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b1000);
      total++;
      if ({gnt, busy, timeout} !== {4'b1000, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL en_frozen_grant edge %0d: gnt=%b busy=%b to=%b want 1000 1 0",
                 i, gnt, busy, timeout);
      end
    end
    // two enabled cycles remain in this tenure (hold count froze at 2)
    step(1'b1, 4'b1000);
    step(1'b1, 4'b1000);
    total++;
    if ({gnt, timeout} !== {4'b1000, 1'b0}) begin
      bad++;
      $display("FAIL en_resume: gnt=%b to=%b want 1000 0", gnt, timeout);
    end
    step(1'b0, 4'b0000);
    total++;
    if ({gnt, token, busy, timeout} !== {4'b0000, 4'b0001, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL en_drop_release: got gnt=%b token=%b busy=%b to=%b want 0000 0001 0 0",
               gnt, token, busy, timeout);
    end
  endtask

  task automatic test_random();
    logic         e;
    logic [N-1:0] r;
    r = '0;
    do_reset(1'b1, 4'b0000);
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      step(e, r);
      total++;
      if ({gnt, token, busy, timeout} !== {exp_gnt(), exp_tok(), m_busy, m_to}) begin
        bad++;
        $display("FAIL random_model edge %0d: en=%b req=%b got %b %b %b %b want %b %b %b %b",
                 i, e, r, gnt, token, busy, timeout, exp_gnt(), exp_tok(), m_busy, m_to);
      end
      total++;
      if ($countones(gnt) > 1 || (busy && gnt !== token) || $countones(token) != 1) begin
        bad++;
        $display("FAIL random_invariant edge %0d: gnt=%b token=%b busy=%b", i, gnt, token, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    test_reset();
    test_timeout();
    test_walk();
    test_drop();
    test_all_req();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
